// File: rtl/demux_pkg.sv
// rtl/demux_pkg.sv - shared defaults and select-width helper for demux_stream_n
package demux_pkg;

  localparam int DEFAULT_DATA_W = 8;
  localparam int DEFAULT_N_CH   = 4;
  localparam int DEFAULT_CNT_W  = 8;

  // Smallest w with 2**w >= value; used to derive the select width.
  function automatic int clog2(input int value);
    int w;
    w = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) w = i + 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/demux_out_slot.sv
// rtl/demux_out_slot.sv - one-entry valid/ready output register for one channel
//
// Ports:
//   clk, rst    clock, asynchronous active-high reset
//   load        write load_data this edge (only asserted when can_accept)
//   load_data   word to store
//   out_ready   consumer ready
//   out_valid   slot holds a word
//   out_data    held word; keeps its last value after a drain
//   can_accept  slot is empty or being drained this cycle
module demux_out_slot
  import demux_pkg::*;
#(
  parameter int DATA_W = DEFAULT_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [DATA_W-1:0] load_data,
  input  logic              out_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic              can_accept
);

  assign can_accept = !out_valid || out_ready;

  // Load wins over drain so a simultaneous drain+write keeps the slot full.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (load) begin
      out_valid <= 1'b1;
      out_data  <= load_data;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/demux_stream_n.sv
// rtl/demux_stream_n.sv - valid/ready stream demux to N_CH registered channels
//
// Optional broadcast feature: define DEMUX_BCAST_EN to add port in_bcast.
//
// Ports:
//   clk, rst    clock, asynchronous active-high reset
//   in_valid    input word valid
//   in_ready    input accepted when in_valid && in_ready (combinational)
//   in_data     input payload
//   in_sel      destination channel; >= N_CH drops the word
//   in_bcast    (DEMUX_BCAST_EN only) write the word to every channel
//   out_valid   per-channel valid
//   out_ready   per-channel consumer ready
//   out_data    channel i at [i*DATA_W +: DATA_W]
//   drop_cnt    saturating count of out-of-range words
module demux_stream_n
  import demux_pkg::*;
#(
  parameter int DATA_W = DEFAULT_DATA_W,
  parameter int N_CH   = DEFAULT_N_CH,
  parameter int SEL_W  = clog2(N_CH),
  parameter int CNT_W  = DEFAULT_CNT_W
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [DATA_W-1:0]      in_data,
  input  logic [SEL_W-1:0]       in_sel,
`ifdef DEMUX_BCAST_EN
  input  logic                   in_bcast,
`endif
  output logic [N_CH-1:0]        out_valid,
  input  logic [N_CH-1:0]        out_ready,
  output logic [N_CH*DATA_W-1:0] out_data,
  output logic [CNT_W-1:0]       drop_cnt
);

  localparam int SEL_SPAN = 1 << SEL_W;

  logic [N_CH-1:0]     can_accept;
  logic [N_CH-1:0]     load;
  logic [SEL_SPAN-1:0] accept_pad;
  logic                in_range;
  logic                sel_ready;
  logic                accept;
  logic                drop;

  // Pad can_accept to the full select span so any in_sel indexes safely;
  // out-of-range entries are never used because in_range overrides them.
  always_comb begin
    accept_pad             = '0;
    accept_pad[N_CH-1:0]   = can_accept;
  end

  assign in_range  = int'(in_sel) < N_CH;
  assign sel_ready = in_range ? accept_pad[in_sel] : 1'b1;
  assign accept    = in_valid && in_ready;

`ifdef DEMUX_BCAST_EN
  logic bcast_req;
  assign bcast_req = in_valid && in_bcast;
  assign in_ready  = !rst && (bcast_req ? &can_accept : sel_ready);
  assign drop      = accept && !bcast_req && !in_range;
`else
  assign in_ready  = !rst && sel_ready;
  assign drop      = accept && !in_range;
`endif

  for (genvar i = 0; i < N_CH; i++) begin : g_slot
`ifdef DEMUX_BCAST_EN
    assign load[i] = accept && (bcast_req || (in_sel == SEL_W'(i)));
`else
    assign load[i] = accept && (in_sel == SEL_W'(i));
`endif

    demux_out_slot #(
      .DATA_W (DATA_W)
    ) u_slot (
      .clk        (clk),
      .rst        (rst),
      .load       (load[i]),
      .load_data  (in_data),
      .out_ready  (out_ready[i]),
      .out_valid  (out_valid[i]),
      .out_data   (out_data[i*DATA_W +: DATA_W]),
      .can_accept (can_accept[i])
    );
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      drop_cnt <= '0;
    end else if (drop && (drop_cnt != '1)) begin
      drop_cnt <= drop_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_demux_stream_n.sv
// tb/tb_demux_stream_n.sv - randomized self-checking bench for demux_stream_n
module tb_demux_stream_n;

  localparam int DATA_W = 8;
  localparam int N_CH   = 3;
  localparam int SEL_W  = 2;
  localparam int CNT_W  = 8;

  logic                   clk = 1'b0;
  logic                   rst;
  logic                   in_valid;
  logic                   in_ready;
  logic [DATA_W-1:0]      in_data;
  logic [SEL_W-1:0]       in_sel;
  logic                   bcast;
  logic [N_CH-1:0]        out_valid;
  logic [N_CH-1:0]        out_ready;
  logic [N_CH*DATA_W-1:0] out_data;
  logic [CNT_W-1:0]       drop_cnt;

  always #5 clk = ~clk;

  demux_stream_n #(
    .DATA_W (DATA_W),
    .N_CH   (N_CH),
    .SEL_W  (SEL_W),
    .CNT_W  (CNT_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_sel    (in_sel),
`ifdef DEMUX_BCAST_EN
    .in_bcast  (bcast),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .drop_cnt  (drop_cnt)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model: what each channel should hold and the drop total.
  logic            m_valid [N_CH];
  logic [7:0]      m_data  [N_CH];
  int              m_drop;

  task automatic model_reset();
    for (int c = 0; c < N_CH; c++) begin
      m_valid[c] = 1'b0;
      m_data[c]  = 8'h00;
    end
    m_drop = 0;
  endtask

  function automatic logic model_ready();
    if (rst) return 1'b0;
    if (in_valid && bcast) begin
      for (int c = 0; c < N_CH; c++)
        if (m_valid[c] && !out_ready[c]) return 1'b0;
      return 1'b1;
    end
    if (int'(in_sel) < N_CH) return !m_valid[int'(in_sel)] || out_ready[int'(in_sel)];
    return 1'b1;
  endfunction

  task automatic check_outputs();
    for (int c = 0; c < N_CH; c++) begin
      check($sformatf("out_valid[%0d]", c), out_valid[c], m_valid[c]);
      check($sformatf("out_data[%0d]", c), out_data[c*DATA_W +: DATA_W], m_data[c]);
    end
    check("drop_cnt", drop_cnt, m_drop);
  endtask

  // Inputs are driven just after a rising edge; check in_ready, take the
  // edge, update the model, then check the registered outputs.
  task automatic cycle();
    logic exp_ready;
    logic acc;
    #1;
    exp_ready = model_ready();
    check("in_ready", in_ready, exp_ready);
    acc = in_valid && exp_ready;
    @(posedge clk);
    for (int c = 0; c < N_CH; c++) begin
      if (acc && (bcast || int'(in_sel) == c)) begin
        m_valid[c] = 1'b1;
        m_data[c]  = in_data;
      end else if (out_ready[c]) begin
        m_valid[c] = 1'b0;
      end
    end
    if (acc && !bcast && int'(in_sel) >= N_CH && m_drop < 255) m_drop++;
    #1;
    check_outputs();
  endtask

  task automatic drive(input logic v, input logic [SEL_W-1:0] s, input logic [7:0] d);
    in_valid = v;
    in_sel   = s;
    in_data  = d;
  endtask

  initial begin
    rst = 1'b1;
    bcast = 1'b0;
    out_ready = '0;
    drive(1'b0, 2'd0, 8'h00);
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("in_ready_in_reset", in_ready, 1'b0);
    check_outputs();
    rst = 1'b0;

    // Asynchronous reset while ch2 holds 0xA5 and drop_cnt is nonzero
    drive(1'b1, 2'd3, 8'hEE); cycle();
    drive(1'b1, 2'd2, 8'hA5); cycle();
    drive(1'b0, 2'd0, 8'h00); cycle();
    #2;
    rst = 1'b1;
    model_reset();
    #1;
    check("async_rst_valid", out_valid, 3'b000);
    check("async_rst_drop", drop_cnt, 0);
    check("async_rst_ready", in_ready, 1'b0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Routing sweep including one out-of-range select
    out_ready = '1;
    for (int k = 0; k < 4; k++) begin
      drive(1'b1, SEL_W'(k), 8'(8'h11 * (k + 1)));
      cycle();
    end
    drive(1'b0, 2'd0, 8'h00); cycle();

    // Back-pressure isolation on ch1
    out_ready = 3'b101;
    drive(1'b1, 2'd1, 8'h5A); cycle();
    drive(1'b1, 2'd1, 8'h6B); cycle();
    cycle();
    out_ready = 3'b111;
    cycle();
    drive(1'b1, 2'd2, 8'h7C); cycle();
    drive(1'b0, 2'd0, 8'h00); cycle();

    // Simultaneous drain and write on ch0
    drive(1'b1, 2'd0, 8'h01); cycle();
    drive(1'b1, 2'd0, 8'h02); cycle();
    drive(1'b0, 2'd0, 8'h00); cycle();

    // Out-of-range flood saturates drop_cnt
    for (int n = 0; n < 300; n++) begin
      drive(1'b1, 2'd3, 8'($urandom));
      cycle();
    end
    check("drop_saturated", drop_cnt, 255);
    drive(1'b0, 2'd0, 8'h00); cycle();

`ifdef DEMUX_BCAST_EN
    // Broadcast blocked by a stalled full ch2, then released
    out_ready = 3'b000;
    drive(1'b1, 2'd2, 8'h99); cycle();
    bcast = 1'b1;
    drive(1'b1, 2'd0, 8'hC3); cycle();
    out_ready = 3'b100;
    cycle();
    bcast = 1'b0;
    drive(1'b0, 2'd0, 8'h00); cycle();
`endif

    // Fresh reset, then random traffic against the model
    #2;
    rst = 1'b1;
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int n = 0; n < 500; n++) begin
      drive(($urandom % 4) != 0, SEL_W'($urandom), 8'($urandom));
      out_ready = N_CH'($urandom);
`ifdef DEMUX_BCAST_EN
      bcast = ($urandom % 6) == 0;
`endif
      cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
